// File: rtl/note_pkg.sv
// Shared note-mapping constants for the FFT peak picker: note table, codes and FSM states.
package note_pkg;
  localparam int N_NOTES = 48;
  localparam int NOTE_AW = 9;

  typedef logic [7:0] note_t;
  localparam note_t NOTE_REST = 8'd0;

  // Inclusive upper bin of each note; note k+1 covers (NOTE_BIN_HI[k-1], NOTE_BIN_HI[k]].
  localparam logic [NOTE_AW-1:0] NOTE_BIN_HI [N_NOTES] = '{
    9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
    9'd11,  9'd12,  9'd13,  9'd14,  9'd15,  9'd16,  9'd17,  9'd18,
    9'd19,  9'd20,  9'd22,  9'd24,  9'd26,  9'd28,  9'd30,  9'd32,
    9'd34,  9'd36,  9'd38,  9'd40,  9'd43,  9'd46,  9'd49,  9'd52,
    9'd55,  9'd58,  9'd62,  9'd66,  9'd70,  9'd74,  9'd78,  9'd82,
    9'd87,  9'd92,  9'd97,  9'd102, 9'd107, 9'd112, 9'd116, 9'd120
  };

  typedef enum logic [1:0] {IDLE, MAP, EMIT} state_t;
endpackage

// File: rtl/peak_to_note.sv
// Fixed-latency linear search of the note table for a snapshot bin; rest is forced for weak or absent peaks.
module peak_to_note
  import note_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MAG_W      = 17,
  parameter int MAG_THRESH = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  snap_has,
  input  logic [ADDR_WIDTH-1:0] snap_bin,
  input  logic [MAG_W-1:0]      snap_mag,
  output note_t                 note,
  output logic                  done
);
  localparam int KW = $clog2(N_NOTES);
  localparam logic [KW-1:0]    K_LAST = KW'(N_NOTES - 1);
  localparam logic [MAG_W-1:0] THRESH = MAG_W'(MAG_THRESH);

  logic          busy;
  logic          found;
  logic [KW-1:0] k_q;
  note_t         note_q;
  logic          hit;

  assign hit = snap_bin <= ADDR_WIDTH'(NOTE_BIN_HI[k_q]);

  // The scan never exits early so the result always lands N_NOTES cycles after start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      found  <= 1'b0;
      k_q    <= '0;
      note_q <= NOTE_REST;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        found  <= 1'b0;
        k_q    <= '0;
        note_q <= NOTE_REST;
      end else if (busy) begin
        if (!found && hit) begin
          found  <= 1'b1;
          note_q <= note_t'(k_q) + note_t'(1);
        end
        if (k_q == K_LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          k_q <= k_q + KW'(1);
        end
      end
    end
  end

  assign note = (!snap_has || (snap_mag < THRESH) || !found) ? NOTE_REST : note_q;
endmodule

// File: rtl/fft_peak_note.sv
// Per-frame FFT peak picker: |re|+|im| pipeline, in-range running max, snapshot and note-emit FSM.
module fft_peak_note
  import note_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int MIN_BIN    = 3,
  parameter int MAX_BIN    = 120,
  parameter int MAG_THRESH = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        bin_valid,
  input  logic signed [BIT_WIDTH-1:0] bin_re,
  input  logic signed [BIT_WIDTH-1:0] bin_im,
  input  logic [ADDR_WIDTH-1:0]       bin_idx,
  input  logic                        bin_last,
  output note_t                       note_out,
  output logic                        note_dec,
  output logic [BIT_WIDTH:0]          peak_mag,
  output logic                        overrun
);
  localparam int MAG_W = BIT_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] MIN_IDX = ADDR_WIDTH'(MIN_BIN);
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(MAX_BIN);

  // One extra bit makes -2^(W-1) representable as a positive magnitude.
  function automatic logic [MAG_W-1:0] abs_sum(input logic signed [BIT_WIDTH-1:0] re,
                                               input logic signed [BIT_WIDTH-1:0] im);
    logic signed [MAG_W-1:0] re_x, im_x;
    logic [MAG_W-1:0]        re_a, im_a;
    re_x = {re[BIT_WIDTH-1], re};
    im_x = {im[BIT_WIDTH-1], im};
    re_a = re_x[MAG_W-1] ? -re_x : re_x;
    im_a = im_x[MAG_W-1] ? -im_x : im_x;
    return re_a + im_a;
  endfunction

  logic                  vld_p0, last_p0;
  logic [MAG_W-1:0]      mag_p0;
  logic [ADDR_WIDTH-1:0] idx_p0;

  logic                  max_has_p1;
  logic [MAG_W-1:0]      max_mag_p1;
  logic [ADDR_WIDTH-1:0] max_bin_p1;

  logic                  snap_has;
  logic [MAG_W-1:0]      snap_mag;
  logic [ADDR_WIDTH-1:0] snap_bin;

  logic                  in_range, upd, frame_end;
  logic                  fin_has;
  logic [MAG_W-1:0]      fin_mag;
  logic [ADDR_WIDTH-1:0] fin_bin;

  state_t state_q, state_d;
  logic   start;
  note_t  map_note;
  logic   map_done;

  // Stage p0: magnitude
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= bin_valid;
      last_p0 <= bin_valid & bin_last;
    end
  end

  always_ff @(posedge clk) begin
    if (bin_valid) begin
      mag_p0 <= abs_sum(bin_re, bin_im);
      idx_p0 <= bin_idx;
    end
  end

  // Stage p1: running max and frame snapshot
  always_comb begin
    in_range  = vld_p0 && (idx_p0 >= MIN_IDX) && (idx_p0 <= MAX_IDX);
    upd       = in_range && (!max_has_p1 || (mag_p0 > max_mag_p1));
    frame_end = vld_p0 && last_p0;
    fin_has   = max_has_p1 | in_range;
    fin_mag   = upd ? mag_p0 : max_mag_p1;
    fin_bin   = upd ? idx_p0 : max_bin_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_has_p1 <= 1'b0;
      max_mag_p1 <= '0;
      max_bin_p1 <= '0;
      snap_has   <= 1'b0;
      snap_mag   <= '0;
      snap_bin   <= '0;
    end else if (frame_end) begin
      max_has_p1 <= 1'b0;
      max_mag_p1 <= '0;
      max_bin_p1 <= '0;
      if (state_q == IDLE) begin
        snap_has <= fin_has;
        snap_mag <= fin_mag;
        snap_bin <= fin_bin;
      end
    end else if (upd) begin
      max_has_p1 <= 1'b1;
      max_mag_p1 <= mag_p0;
      max_bin_p1 <= idx_p0;
    end
  end

  // Stage p2: note search and emit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (frame_end) begin
        start   = 1'b1;
        state_d = MAP;
      end
      MAP:  if (map_done) state_d = EMIT;
      EMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  peak_to_note #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAG_W      (MAG_W),
    .MAG_THRESH (MAG_THRESH)
  ) u_map (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .snap_has (snap_has),
    .snap_bin (snap_bin),
    .snap_mag (snap_mag),
    .note     (map_note),
    .done     (map_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_out <= NOTE_REST;
      note_dec <= 1'b0;
      peak_mag <= '0;
      overrun  <= 1'b0;
    end else begin
      note_dec <= (state_q == EMIT);
      overrun  <= frame_end && (state_q != IDLE);
      if (state_q == EMIT) begin
        note_out <= map_note;
        peak_mag <= snap_mag;
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_note.sv
// Directed bench for fft_peak_note: frames from a bin table, strobes captured by a monitor.
module tb_fft_peak_note;
  logic               clk;
  logic               reset;
  logic               bin_valid;
  logic signed [15:0] bin_re;
  logic signed [15:0] bin_im;
  logic [8:0]         bin_idx;
  logic               bin_last;
  logic [7:0]         note_out;
  logic               note_dec;
  logic [16:0]        peak_mag;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int ovr_cnt  = 0;
  int q_note[$];
  int q_mag[$];
  int q_cyc[$];
  int re_tab[128];
  int im_tab[128];

  localparam int LAT = 51;

  fft_peak_note dut (
    .clk       (clk),
    .reset     (reset),
    .bin_valid (bin_valid),
    .bin_re    (bin_re),
    .bin_im    (bin_im),
    .bin_idx   (bin_idx),
    .bin_last  (bin_last),
    .note_out  (note_out),
    .note_dec  (note_dec),
    .peak_mag  (peak_mag),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_dec === 1'b1) begin
      q_note.push_back(int'(note_out));
      q_mag.push_back(int'(peak_mag));
      q_cyc.push_back(cyc);
    end
    if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
  end

  task automatic fill_bg(input int re, input int im);
    for (int i = 0; i < 128; i++) begin
      re_tab[i] = re;
      im_tab[i] = im;
    end
  endtask

  task automatic send_bin(input int idx, input int re, input int im, input bit last);
    bin_valid = 1'b1;
    bin_idx   = 9'(idx);
    bin_re    = 16'(re);
    bin_im    = 16'(im);
    bin_last  = last;
    @(posedge clk);
    #1;
    if (last) last_cyc = cyc;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
  endtask

  task automatic send_frame(input int start, input int n);
    for (int i = start; i < start + n; i++)
      send_bin(i, re_tab[i], im_tab[i], i == start + n - 1);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int c;
    c = 0;
    while (q_note.size() < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bin_valid = 1'b0; bin_last = 1'b0; bin_re = '0; bin_im = '0; bin_idx = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (note_out !== 8'd0) begin failures++; $display("FAIL reset_note_out got=%0d want=0", note_out); end
    checks++; if (note_dec !== 1'b0) begin failures++; $display("FAIL reset_note_dec got=%0b want=0", note_dec); end
    checks++; if (peak_mag !== 17'd0) begin failures++; $display("FAIL reset_peak_mag got=%0d want=0", peak_mag); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
  endtask

  task automatic test_single_tone();
    int base, ob;
    base = q_note.size(); ob = ovr_cnt;
    fill_bg(60, -40);
    re_tab[40] = 3000; im_tab[40] = -1000;
    send_frame(0, 128);
    wait_strobes(base + 1, 200);
    checks++; if (q_note.size() - base !== 1) begin failures++; $display("FAIL tone_strobes got=%0d want=1", q_note.size() - base); end
    if (q_note.size() > base) begin
      checks++; if (q_note[base] !== 28) begin failures++; $display("FAIL tone_note got=%0d want=28", q_note[base]); end
      checks++; if (q_mag[base] !== 4000) begin failures++; $display("FAIL tone_mag got=%0d want=4000", q_mag[base]); end
      checks++; if (q_cyc[base] - last_cyc !== LAT) begin failures++; $display("FAIL tone_latency got=%0d want=%0d", q_cyc[base] - last_cyc, LAT); end
    end
    checks++; if (ovr_cnt - ob !== 0) begin failures++; $display("FAIL tone_overrun got=%0d want=0", ovr_cnt - ob); end
  endtask

  task automatic test_quiet();
    int base;
    base = q_note.size();
    fill_bg(300, 200);
    send_frame(0, 128);
    wait_strobes(base + 1, 200);
    checks++; if (q_note.size() - base !== 1) begin failures++; $display("FAIL quiet_strobes got=%0d want=1", q_note.size() - base); end
    if (q_note.size() > base) begin
      checks++; if (q_note[base] !== 0) begin failures++; $display("FAIL quiet_note got=%0d want=0", q_note[base]); end
      checks++; if (q_mag[base] !== 500) begin failures++; $display("FAIL quiet_mag got=%0d want=500", q_mag[base]); end
    end
  endtask

  task automatic test_ties();
    int base;
    base = q_note.size();
    fill_bg(100, 0);
    re_tab[2]  = 9000;
    re_tab[10] = 5000;
    re_tab[20] = -2500; im_tab[20] = 2500;
    send_frame(0, 128);
    wait_strobes(base + 1, 200);
    checks++; if (q_note.size() - base !== 1) begin failures++; $display("FAIL ties_strobes got=%0d want=1", q_note.size() - base); end
    if (q_note.size() > base) begin
      checks++; if (q_note[base] !== 8) begin failures++; $display("FAIL ties_note got=%0d want=8", q_note[base]); end
      checks++; if (q_mag[base] !== 5000) begin failures++; $display("FAIL ties_mag got=%0d want=5000", q_mag[base]); end
    end
  endtask

  task automatic test_extremes();
    int base;
    base = q_note.size();
    fill_bg(100, 0);
    re_tab[50] = -32768; im_tab[50] = -32768;
    send_frame(0, 128);
    wait_strobes(base + 1, 200);
    checks++; if (q_note.size() - base !== 1) begin failures++; $display("FAIL ext_strobes got=%0d want=1", q_note.size() - base); end
    if (q_note.size() > base) begin
      checks++; if (q_note[base] !== 32) begin failures++; $display("FAIL ext_note got=%0d want=32", q_note[base]); end
      checks++; if (q_mag[base] !== 65536) begin failures++; $display("FAIL ext_mag got=%0d want=65536", q_mag[base]); end
    end
  endtask

  task automatic test_back_to_back();
    int base, ob;
    int exp_note[3];
    exp_note[0] = 23; exp_note[1] = 35; exp_note[2] = 23;
    base = q_note.size(); ob = ovr_cnt;
    fill_bg(100, 0); re_tab[30] = 2000; send_frame(0, 128);
    fill_bg(100, 0); re_tab[60] = 2000; send_frame(0, 128);
    fill_bg(100, 0); re_tab[30] = 2000; send_frame(0, 128);
    checks++; if (ovr_cnt - ob !== 0) begin failures++; $display("FAIL b2b_no_overrun got=%0d want=0", ovr_cnt - ob); end
    fill_bg(100, 0); send_frame(3, 4);
    wait_strobes(base + 3, 200);
    checks++; if (q_note.size() - base !== 3) begin failures++; $display("FAIL b2b_strobes got=%0d want=3", q_note.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (q_note.size() > base + i) begin
        checks++; if (q_note[base + i] !== exp_note[i]) begin failures++; $display("FAIL b2b_note%0d got=%0d want=%0d", i, q_note[base + i], exp_note[i]); end
        checks++; if (q_mag[base + i] !== 2000) begin failures++; $display("FAIL b2b_mag%0d got=%0d want=2000", i, q_mag[base + i]); end
      end
    end
    checks++; if (ovr_cnt - ob !== 1) begin failures++; $display("FAIL b2b_overrun got=%0d want=1", ovr_cnt - ob); end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    fill_bg(100, 0);
    re_tab[15] = 6000;
    for (int i = 0; i < 25; i++) send_bin(i, re_tab[i], im_tab[i], 1'b0);
    checks++; if (note_out === 8'd0) begin failures++; $display("FAIL rst_pre_note got=%0d want=nonzero", note_out); end
    bin_valid = 1'b1; bin_idx = 9'd25; bin_re = 16'sd100; bin_im = 16'sd0; bin_last = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (note_out !== 8'd0) begin failures++; $display("FAIL rst_async_note got=%0d want=0", note_out); end
    checks++; if (peak_mag !== 17'd0) begin failures++; $display("FAIL rst_async_mag got=%0d want=0", peak_mag); end
    checks++; if (note_dec !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_async_strobes got=%0b%0b want=00", note_dec, overrun); end
    bin_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = q_note.size();
    fill_bg(100, 0);
    re_tab[70] = 3000;
    send_frame(0, 128);
    wait_strobes(base + 1, 200);
    checks++; if (q_note.size() - base !== 1) begin failures++; $display("FAIL rst_strobes got=%0d want=1", q_note.size() - base); end
    if (q_note.size() > base) begin
      checks++; if (q_note[base] !== 37) begin failures++; $display("FAIL rst_note got=%0d want=37", q_note[base]); end
      checks++; if (q_mag[base] !== 3000) begin failures++; $display("FAIL rst_mag got=%0d want=3000", q_mag[base]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_tone();
    test_quiet();
    test_ties();
    test_extremes();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_peak_note.md
Name: fft_peak_note

Overview:
- Upstream neighbour of the note-duration stage.
- Consumes the per-frame FFT bin stream and finds the maximum-magnitude bin within the musical range.
- Maps that bin to an 8-bit note code and emits one note_out/note_dec pulse per frame; the duration stage consumes these as note_in/note_dec.
- Quiet frames (peak below threshold) and out-of-range peaks map to the rest code 0.

Parameters:
- BIT_WIDTH, 16: width of signed FFT real/imag samples.
- ADDR_WIDTH, 9: bin index width (512-point FFT).
- MIN_BIN, 3: lowest bin considered.
- MAX_BIN, 120: highest bin considered.
- MAG_THRESH, 1024: minimum peak magnitude (|re|+|im|) for a note; below it, the output is rest.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bin_valid  in  1  bin_re/bin_im/bin_idx valid this cycle
- bin_re  in  BIT_WIDTH  signed real part
- bin_im  in  BIT_WIDTH  signed imaginary part
- bin_idx  in  ADDR_WIDTH  bin index of current sample
- bin_last  in  1  qualifies the final bin of a frame (only meaningful with bin_valid)
- note_out  out  8  note code: 0 = rest, 1..N_NOTES
- note_dec  out  1  one-cycle strobe; note_out valid
- peak_mag  out  BIT_WIDTH+1  magnitude of the winning bin, valid with note_dec
- overrun  out  1  one-cycle strobe; a frame result was discarded

Behaviour:
- Reset: asynchronous, active-high. Clears note_out, note_dec, peak_mag, overrun, the running max, the snapshot and the FSM (state IDLE). Reset mid-frame discards the partial frame. The first frame after reset starts at the next bin_valid.
- Stage 1 (registered): mag = |re| + |im|, unsigned, BIT_WIDTH+1 bits. No saturation is needed; -2^(BIT_WIDTH-1) gives 2^(BIT_WIDTH-1) exactly. The stage also registers idx, valid and last.
- Stage 2, running max:
  - Update when the stage-1 sample is valid, MIN_BIN <= idx <= MAX_BIN, and mag > max_mag (strict).
  - Ties keep the lower bin.
  - The first in-range bin of each frame loads unconditionally.
  - If no in-range bin occurs, the frame has no candidate, which maps to rest.
- Frame end: in the cycle the stage-1 sample carries last, the final max (including that bin) is copied into a snapshot. The running max clears for the next frame, so accumulation is back-to-back with no dead cycle.
- FSM states:
  - IDLE → MAP on snapshot load.
  - MAP: iterative search, one table entry per cycle for k = 0..N_NOTES-1. The result is the first k with snap_bin <= NOTE_BIN_HI[k], giving note k+1. The search always runs N_NOTES cycles, so latency is fixed. After N_NOTES cycles: → EMIT.
  - EMIT: note_dec = 1 and peak_mag is driven for one cycle; → IDLE.
- Forced rest: snap_mag < MAG_THRESH, no candidate, or snap_bin > NOTE_BIN_HI[N_NOTES-1] all give note_out = 0, still with a note_dec strobe.
- Latency: if bin_valid&bin_last is sampled at edge T, note_dec is high in cycle T+N_NOTES+3.
- note_out holds its value until the next EMIT. note_dec and overrun are otherwise 0.
- Overrun: if a frame end arrives while the FSM is not IDLE, that frame's snapshot is discarded and overrun pulses. The in-flight search completes unaffected.
- bin_valid gaps inside a frame are allowed. bin_last without bin_valid is ignored.

Decomposition:
- Package note_pkg:
  - N_NOTES = 48
  - NOTE_REST = 8'd0
  - NOTE_BIN_HI[N_NOTES] (ADDR_WIDTH-bit upper-bin boundaries, ascending)
  - typedef note_t = logic [7:0]
  - FSM enum state_t {IDLE, MAP, EMIT}
- Sub-module peak_to_note: takes snapshot bin/mag plus a start strobe, runs the MAP search, and returns note plus a done strobe. The top module keeps the magnitude pipeline, running max, snapshot and overrun logic.

Test Plan:
- Single tone: frame with bin 40 at re=3000, im=-1000 (mag 4000), other bins mag 100 → one note_dec at T+N_NOTES+3; note_out = first k with NOTE_BIN_HI[k] >= 40, plus 1; peak_mag = 4000.
- Quiet frame: all bins mag 500 (< 1024) → note_dec with note_out = 0, peak_mag = 500.
- Ties and range: bin 2 mag 9000 (out of range), bins 10 and 20 both mag 5000 → winner is bin 10.
- Extremes: re = -32768, im = -32768 at bin 50 → peak_mag = 65536, no wrap, note for bin 50.
- Back-to-back frames: 3 consecutive frames with a peak at bin 30, then bin 60, then bin 30 → three strobes with the matching codes, no overrun. Then a 4-bin frame (MIN_BIN..MIN_BIN+3) whose frame end lands during MAP → overrun = 1 once, and only one strobe for the earlier frame.
- Reset mid-frame: assert reset on bin 25 of a frame (peak already seen at bin 15) → all outputs 0 immediately. The next complete frame with a peak at bin 70 yields exactly one strobe, with note for bin 70.
